// File: rtl/fip_pkg.sv
// Shared types and constants for the sequential fixed-point divider.
// Holds the FSM encoding, iteration count and saturation limits.
package fip_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        FINAL,
        DONE
    } fip_state_e;

    // Number of restoring steps: one per numerator bit.
    function automatic int fip_iter(input int w, input int frac);
        return w + frac;
    endfunction

    // Largest positive W-bit two's-complement value.
    function automatic logic [63:0] fip_max_pos(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Magnitude (and bit pattern) of the most negative W-bit value.
    function automatic logic [63:0] fip_min_neg(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/fip_div_seq_step.sv
// One radix-2 restoring division step.
// Shifts in a numerator bit and keeps the trial difference when it is non-negative.
module fip_udiv_step
    import fip_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] rem_i,
    input  logic [W-1:0] div_i,
    input  logic         bit_i,
    output logic [W-1:0] rem_o,
    output logic         q_o
);

    logic [W:0] shl;
    logic [W:0] diff;

    // Trial subtract; bit W of the difference is the borrow.
    always_comb begin
        shl   = {rem_i, bit_i};
        diff  = shl - {1'b0, div_i};
        q_o   = ~diff[W];
        rem_o = q_o ? diff[W-1:0] : shl[W-1:0];
    end

endmodule

// File: rtl/fip_div_seq.sv
// Multi-cycle signed fixed-point divider, Q(W-FRAC).FRAC format.
// Restoring iteration with valid/ready handshake and saturating result.
module fip_div_seq
    import fip_pkg::*;
#(
    parameter int W    = 32,
    parameter int FRAC = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_valid,
    output logic         o_in_ready,
    input  logic [W-1:0] i_dividend,
    input  logic [W-1:0] i_divisor,
    output logic         o_valid,
    input  logic         i_out_ready,
    output logic [W-1:0] o_quotient,
    output logic         o_overflow,
    output logic         o_div_zero
);

    localparam int N    = W + FRAC;
    localparam int ITER = fip_iter(W, FRAC);
    localparam int CW   = $clog2(ITER + 1);

    localparam logic [N-1:0] MAXP_N = N'(fip_max_pos(W));
    localparam logic [N-1:0] MINN_N = N'(fip_min_neg(W));
    localparam logic [W-1:0] MAXP_W = W'(fip_max_pos(W));
    localparam logic [W-1:0] MINN_W = W'(fip_min_neg(W));

    fip_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  num_q, num_d;
    logic [N-1:0]  quo_q, quo_d;
    logic [W-1:0]  div_q, div_d;
    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  qout_q, qout_d;
    logic          sign_q, sign_d;
    logic          zero_q, zero_d;
    logic          ovf_q, ovf_d;
    logic          dz_q, dz_d;

    logic [W-1:0]  mag_a;
    logic [W-1:0]  mag_b;
    logic [W-1:0]  step_rem;
    logic          step_q;

    fip_udiv_step #(
        .W(W)
    ) u_step (
        .rem_i(rem_q),
        .div_i(div_q),
        .bit_i(num_q[N-1]),
        .rem_o(step_rem),
        .q_o  (step_q)
    );

    // Operand magnitudes; as unsigned W-bit values |-2^(W-1)| is exact.
    always_comb begin
        mag_a = i_dividend[W-1] ? ('0 - i_dividend) : i_dividend;
        mag_b = i_divisor[W-1]  ? ('0 - i_divisor)  : i_divisor;
    end

    // Next-state and datapath control for accept, iterate, finalise, hold.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        quo_d   = quo_q;
        div_d   = div_q;
        rem_d   = rem_q;
        qout_d  = qout_q;
        sign_d  = sign_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        dz_d    = dz_q;
        unique case (state_q)
            IDLE: begin
                if (i_valid) begin
                    sign_d  = i_dividend[W-1] ^ i_divisor[W-1];
                    num_d   = N'(mag_a) << FRAC;
                    div_d   = mag_b;
                    zero_d  = (i_divisor == '0);
                    rem_d   = '0;
                    quo_d   = '0;
                    cnt_d   = CW'(ITER);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                rem_d = step_rem;
                num_d = num_q << 1;
                quo_d = {quo_q[N-2:0], step_q};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FINAL;
                end
            end
            FINAL: begin
                ovf_d = 1'b0;
                dz_d  = 1'b0;
                if (zero_q) begin
                    dz_d   = 1'b1;
                    qout_d = sign_q ? MINN_W : MAXP_W;
                end else if (!sign_q && quo_q > MAXP_N) begin
                    ovf_d  = 1'b1;
                    qout_d = MAXP_W;
                end else if (sign_q && quo_q > MINN_N) begin
                    ovf_d  = 1'b1;
                    qout_d = MINN_W;
                end else begin
                    qout_d = sign_q ? ('0 - quo_q[W-1:0])
                                    : quo_q[W-1:0];
                end
                state_d = DONE;
            end
            DONE: begin
                if (i_out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any division in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            num_q   <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            rem_q   <= '0;
            qout_q  <= '0;
            sign_q  <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            quo_q   <= quo_d;
            div_q   <= div_d;
            rem_q   <= rem_d;
            qout_q  <= qout_d;
            sign_q  <= sign_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            dz_q    <= dz_d;
        end
    end

    assign o_in_ready = (state_q == IDLE);
    assign o_valid    = (state_q == DONE);
    assign o_quotient = qout_q;
    assign o_overflow = ovf_q;
    assign o_div_zero = dz_q;

endmodule

// File: tb/tb_fip_div_seq.sv
// Bench for fip_div_seq: Q16.16 and Q8.8 instances, scoreboard vs arithmetic model.
// Stimulus pushes expected results; per-instance monitors pop and compare.
module tb_fip_div_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        vi32, ir32, vo32, or32, ov32, dz32;
    logic [31:0] a32, b32, q32;
    logic        vi16, ir16, vo16, or16, ov16, dz16;
    logic [15:0] a16, b16, q16;

    fip_div_seq #(.W(32), .FRAC(16)) u32 (
        .clk(clk), .rst_n(rst_n),
        .i_valid(vi32), .o_in_ready(ir32),
        .i_dividend(a32), .i_divisor(b32),
        .o_valid(vo32), .i_out_ready(or32),
        .o_quotient(q32), .o_overflow(ov32), .o_div_zero(dz32)
    );

    fip_div_seq #(.W(16), .FRAC(8)) u16 (
        .clk(clk), .rst_n(rst_n),
        .i_valid(vi16), .o_in_ready(ir16),
        .i_dividend(a16), .i_divisor(b16),
        .o_valid(vo16), .i_out_ready(or16),
        .o_quotient(q16), .o_overflow(ov16), .o_div_zero(dz16)
    );

    typedef struct {
        logic [63:0] q;
        logic        ovf;
        logic        dz;
        int          cyc;
    } exp_t;

    exp_t sb[2][$];
    exp_t cur[2];
    bit   pv[2];
    int   WD[2] = '{32, 16};
    int   FR[2] = '{16, 8};
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: exact rational division, truncated, then saturated.
    function automatic exp_t model(input int w, input int f,
                                   input logic [63:0] a, input logic [63:0] b);
        exp_t   e;
        longint xa, xb, mag, maxp;
        bit     neg;
        xa = longint'(a);
        xb = longint'(b);
        if (a[w-1]) xa = xa - (longint'(1) << w);
        if (b[w-1]) xb = xb - (longint'(1) << w);
        maxp = (longint'(1) << (w - 1)) - 1;
        e.ovf = 1'b0;
        e.dz = 1'b0;
        e.cyc = 0;
        if (xb == 0) begin
            e.dz = 1'b1;
            e.q = (xa >= 0) ? maxp : -(maxp + 1);
        end else begin
            mag = ((xa < 0 ? -xa : xa) << f) / (xb < 0 ? -xb : xb);
            neg = (xa < 0) != (xb < 0);
            if (!neg && mag > maxp) begin
                e.ovf = 1'b1;
                e.q = maxp;
            end else if (neg && mag > maxp + 1) begin
                e.ovf = 1'b1;
                e.q = -(maxp + 1);
            end else begin
                e.q = neg ? -mag : mag;
            end
        end
        e.q = e.q & ((64'd1 << w) - 64'd1);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic mon(input int id, input logic v, input logic ir,
                       input logic [63:0] q, input logic ov, input logic dz);
        exp_t e;
        if (v) chk($sformatf("inrdy_while_valid_w%0d", WD[id]), 64'(ir), 64'd0);
        if (v && !pv[id]) begin
            if (sb[id].size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result_w%0d: got %h expected none",
                         WD[id], q);
            end else begin
                e = sb[id].pop_front();
                chk($sformatf("quot_w%0d", WD[id]), q, e.q);
                chk($sformatf("ovf_w%0d", WD[id]), 64'(ov), 64'(e.ovf));
                chk($sformatf("dz_w%0d", WD[id]), 64'(dz), 64'(e.dz));
                chk($sformatf("latency_w%0d", WD[id]), 64'(cyc - e.cyc),
                    64'(WD[id] + FR[id] + 1));
                cur[id] = e;
            end
        end else if (v) begin
            chk($sformatf("hold_quot_w%0d", WD[id]), q, cur[id].q);
            chk($sformatf("hold_ovf_w%0d", WD[id]), 64'(ov), 64'(cur[id].ovf));
        end
        pv[id] = v;
    endtask

    always @(negedge clk) mon(0, vo32, ir32, {32'd0, q32}, ov32, dz32);
    always @(negedge clk) mon(1, vo16, ir16, {48'd0, q16}, ov16, dz16);

    function automatic bit inrdy(input int id);
        return (id == 0) ? ir32 : ir16;
    endfunction

    task automatic drive(input int id, input bit v,
                         input logic [63:0] a, input logic [63:0] b);
        if (id == 0) begin
            vi32 = v; a32 = a[31:0]; b32 = b[31:0];
        end else begin
            vi16 = v; a16 = a[15:0]; b16 = b[15:0];
        end
    endtask

    task automatic issue(input int id, input logic [63:0] a,
                         input logic [63:0] b);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        while (!inrdy(id) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            total++;
            bad++;
            $display("FAIL accept_timeout_w%0d: got busy expected ready", WD[id]);
            return;
        end
        drive(id, 1'b1, a, b);
        @(negedge clk);
        drive(id, 1'b0, a, b);
        e = model(WD[id], FR[id], a, b);
        e.cyc = cyc;
        sb[id].push_back(e);
    endtask

    task automatic drain(input int lim);
        int n = 0;
        while ((sb[0].size() != 0 || sb[1].size() != 0) && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 64'(sb[0].size() + sb[1].size()), 64'd0);
    endtask

    function automatic logic [63:0] rnd_b(input int id);
        logic [63:0] x;
        int          r;
        r = $urandom_range(0, 7);
        if (r == 0) x = 64'd0;
        else if (r < 4) begin
            x = (id == 0) ? 64'($urandom_range(1, 32'h3FFFF))
                          : 64'($urandom_range(1, 32'h3FF));
            if ($urandom_range(0, 1) == 1) x = -x;
        end else x = 64'($urandom);
        return x & ((64'd1 << WD[id]) - 64'd1);
    endfunction

    logic [63:0] da[8] = '{64'h00020000, 64'h00000002, 64'hFFFF0000,
                           64'h7FFFFFFF, 64'h80000000, 64'h80000000,
                           64'h00010000, 64'hFFFF0000};
    logic [63:0] db[8] = '{64'h00020000, 64'h00000003, 64'h00008000,
                           64'h00004000, 64'hFFFF0000, 64'h00010000,
                           64'h00000000, 64'h00000000};
    logic [63:0] ea[4] = '{64'h0200, 64'h7FFF, 64'h8000, 64'hFF00};
    logic [63:0] eb[4] = '{64'h0080, 64'h0001, 64'h0000, 64'h0080};

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vi32 = 0; a32 = 0; b32 = 0; or32 = 1;
        vi16 = 0; a16 = 0; b16 = 0; or16 = 1;
        rst_n = 0;
        repeat (3) @(negedge clk);
        chk("rst_valid32", 64'(vo32), 64'd0);
        chk("rst_inrdy32", 64'(ir32), 64'd1);
        chk("rst_quot32", 64'(q32), 64'd0);
        chk("rst_ovf32", 64'(ov32), 64'd0);
        chk("rst_dz32", 64'(dz32), 64'd0);
        chk("rst_valid16", 64'(vo16), 64'd0);
        chk("rst_inrdy16", 64'(ir16), 64'd1);
        rst_n = 1;

        for (int i = 0; i < 8; i++) issue(0, da[i], db[i]);
        drain(200);

        or32 = 0;
        issue(0, 64'h00070000, 64'h00030000);
        repeat (5) begin
            drive(0, 1'b1, 64'h12345678, 64'h00001000);
            @(negedge clk);
            chk("busy_no_accept", 64'(ir32), 64'd0);
        end
        drive(0, 1'b0, 64'd0, 64'd0);
        for (int n = 0; n < 100 && !vo32; n++) @(negedge clk);
        chk("hold_valid_seen", 64'(vo32), 64'd1);
        repeat (10) @(negedge clk);
        chk("hold_still_valid", 64'(vo32), 64'd1);
        or32 = 1;
        issue(0, 64'hFFFFFFFF, 64'h00020000);
        drain(200);

        issue(0, 64'h00010000, 64'h00030000);
        repeat (20) @(negedge clk);
        chk("busy_inrdy_low", 64'(ir32), 64'd0);
        #2 rst_n = 0;
        #1;
        chk("async_rst_valid", 64'(vo32), 64'd0);
        chk("async_rst_inrdy", 64'(ir32), 64'd1);
        sb[0].delete();
        @(negedge clk);
        rst_n = 1;
        issue(0, 64'h00008000, 64'h00004000);

        for (int i = 0; i < 30; i++) issue(0, 64'($urandom), rnd_b(0));

        for (int i = 0; i < 4; i++) issue(1, ea[i], eb[i]);
        for (int i = 0; i < 30; i++)
            issue(1, 64'($urandom_range(0, 32'hFFFF)), rnd_b(1));

        drain(500);
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
